regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin fairness and a
// full-file clear sweep that takes priority over pending writes.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              clr_done_q, clr_done_d;
    logic              a_gnt, b_gnt;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB;
            rr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Arbitration, sweep sequencing and write-port next state
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        clr_done_d = 1'b0;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;

        case (state_q)
            ARB: begin
                if (clr_start) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = '0;
                    rf_wdata_d = '0;
                end else begin
                    if (a_valid && (!b_valid || !rr_ptr_q)) begin
                        a_gnt = 1'b1;
                    end else if (b_valid) begin
                        b_gnt = 1'b1;
                    end
                    // Only a contested grant moves the pointer, to the loser
                    if (a_valid && b_valid) begin
                        rr_ptr_d = a_gnt;
                    end
                    if (a_gnt && (a_addr != '0)) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = a_addr;
                        rf_wdata_d = a_data;
                    end else if (b_gnt && (b_addr != '0)) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = b_addr;
                        rf_wdata_d = b_data;
                    end
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d    = ARB;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d      = ADDR_W'(cnt_q + 1'b1);
                    rf_we_d    = 1'b1;
                    rf_waddr_d = ADDR_W'(cnt_q + 1'b1);
                    rf_wdata_d = '0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign a_ready  = reset && a_gnt;
    assign b_ready  = reset && b_gnt;
    assign busy     = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table for arbitration, hand-written
// sequences for clear sweep, clear re-pulse and reset-abort.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid, clr_start;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, busy, clr_done, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ea;
        logic        eb;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    vec_t        tbl[11];
    exp_t        sbq[$];
    logic [4:0]  mdl_addr;
    logic [31:0] mdl_data;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .clr_start(clr_start),
        .busy     (busy),
        .clr_done (clr_done),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one vector at a negedge, check readys, score the next-cycle write.
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        clr_start = 1'b0;
        #1;
        chk({nm, "_a_ready"}, 32'(a_ready), 32'(v.ea));
        chk({nm, "_b_ready"}, 32'(b_ready), 32'(v.eb));
        e.we = 1'b0; e.addr = mdl_addr; e.data = mdl_data;
        if (v.ea && v.av && v.aa != 5'd0) begin
            e.we = 1'b1; e.addr = v.aa; e.data = v.ad;
        end else if (v.eb && v.bv && v.ba != 5'd0) begin
            e.we = 1'b1; e.addr = v.ba; e.data = v.bd;
        end
        mdl_addr = e.addr; mdl_data = e.data;
        sbq.push_back(e);
        cycle();
        e = sbq.pop_front();
        chk({nm, "_rf_we"},    32'(rf_we),    32'(e.we));
        chk({nm, "_rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
        chk({nm, "_rf_wdata"}, rf_wdata,      e.data);
    endtask

    initial begin
        exp_t e;
        int   busy_cnt, done_cnt, last_addr;
        bit   repulsed;

        //            av  aa     ad            bv  ba     bd            ea  eb
        tbl[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
        tbl[1]  = '{1'b1, 5'd4, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 5'd4, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 5'd4, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 5'd4, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h12345678, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77777777, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 5'd8, 32'h88888888, 1'b1, 5'd9, 32'h99999999, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 5'd10, 32'hAAAA0000, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0};
        tbl[10] = '{1'b1, 5'd11, 32'hBBBB0000, 1'b1, 5'd12, 32'hCCCC0000, 1'b0, 1'b1};

        reset = 1'b0; clr_start = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        mdl_addr = '0; mdl_data = '0;
        cycle();
        cycle();

        // Reset state, readys held low under reset
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Clear with A pending: A blocked for the sweep, served on first ARB cycle
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hA5A5A5A5;
        b_valid = 1'b0; clr_start = 1'b1;
        #1;
        chk("clr_start_a_ready", 32'(a_ready), 32'd0);
        cycle();
        clr_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            chk($sformatf("sweep%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("sweep%0d_we", k), 32'(rf_we), 32'd1);
            chk($sformatf("sweep%0d_addr", k), 32'(rf_waddr), 32'(k));
            chk($sformatf("sweep%0d_data", k), rf_wdata, 32'd0);
            chk($sformatf("sweep%0d_a_ready", k), 32'(a_ready), 32'd0);
            cycle();
        end
        #1;
        chk("sweep_end_busy", 32'(busy), 32'd0);
        chk("sweep_end_clr_done", 32'(clr_done), 32'd1);
        chk("sweep_end_a_ready", 32'(a_ready), 32'd1);
        e.we = 1'b1; e.addr = 5'd9; e.data = 32'hA5A5A5A5;
        mdl_addr = e.addr; mdl_data = e.data;
        sbq.push_back(e);
        cycle();
        a_valid = 1'b0;
        #1;
        e = sbq.pop_front();
        chk("post_clr_rf_we", 32'(rf_we), 32'(e.we));
        chk("post_clr_rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk("post_clr_rf_wdata", rf_wdata, e.data);
        chk("post_clr_done_low", 32'(clr_done), 32'd0);
        cycle();

        // clr_start re-pulsed mid-sweep is ignored
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        busy_cnt = 0; done_cnt = 0; last_addr = -1; repulsed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (busy && rf_we) last_addr = int'(rf_waddr);
            if (clr_done) done_cnt++;
            if (busy && rf_waddr == 5'd5 && !repulsed) begin
                clr_start = 1'b1; repulsed = 1'b1;
            end else begin
                clr_start = 1'b0;
            end
            cycle();
        end
        chk("repulse_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("repulse_done_count", 32'(done_cnt), 32'd1);
        chk("repulse_last_addr", 32'(last_addr), 32'd31);
        mdl_addr = 5'd31; mdl_data = 32'd0;

        // Reset at sweep address 10 aborts without clr_done
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        chk("abort_at_addr", 32'(rf_waddr), 32'd10);
        reset = 1'b0;
        cycle();
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66666666;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rf_we", 32'(rf_we), 32'd0);
        chk("abort_clr_done", 32'(clr_done), 32'd0);
        chk("abort_a_ready_in_reset", 32'(a_ready), 32'd0);
        cycle();
        chk("abort_clr_done_late", 32'(clr_done), 32'd0);
        reset = 1'b1;
        mdl_addr = '0; mdl_data = '0;
        step('{1'b1, 5'd6, 32'h66666666, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0}, "post_abort");
        step('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0}, "idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
